// File: rtl/data_memory_ctrl_pkg.sv
// dmem_pkg: size codes, FSM states and size/extension helpers for data_memory_ctrl
package dmem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    return size == SZ_BYTE ? 3'd1 : size == SZ_HALF ? 3'd2 : size == SZ_WORD ? 3'd4 : 3'd0;
  endfunction
  function automatic logic [31:0] extend(input logic [31:0] data, input logic [1:0] size, input logic uns);
    return size == SZ_BYTE ? {{24{~uns & data[7]}}, data[7:0]} :
           size == SZ_HALF ? {{16{~uns & data[15]}}, data[15:0]} : data;
  endfunction
endpackage

// File: rtl/data_memory_ctrl_byte_array.sv
// dmem_byte_array: byte storage with four lanes; lane i is the byte at offset+i
module dmem_byte_array #(
  parameter int DEPTH_BYTES = 4096
) (
  input  logic                           clock,
  input  logic [$clog2(DEPTH_BYTES)-1:0] offset,
  input  logic [3:0]                     we,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);
  localparam int AW = $clog2(DEPTH_BYTES);
  logic [7:0] mem [DEPTH_BYTES];
  // commit each enabled lane; lane 0 carries the most significant byte
  always_ff @(posedge clock)
    for (int i = 0; i < 4; i++)
      if (we[i]) mem[offset + AW'(i)] <= wdata[31-8*i -: 8];
  // combinational big-endian 4-byte read starting at offset
  always_comb begin
    rdata = '0;
    for (int i = 0; i < 4; i++) rdata[31-8*i -: 8] = mem[offset + AW'(i)];
  end
endmodule

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: big-endian byte/half/word data memory with valid/ready request and response
// Optional range checking against DEPTH_BYTES is enabled by defining DMEM_BOUNDS_CHECK_EN.
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter int              ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8002_0000,
  parameter int              DEPTH_BYTES = 4096,
  parameter int              WAIT_STATES = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_error
);
  localparam int AW = $clog2(DEPTH_BYTES);
  state_t state, state_n;
  logic [3:0] wcnt;
  logic accept, misalign, range_err, err;
  logic [ADDR_W-1:0] off_full;
  logic [3:0] lane_we;
  logic [31:0] lane_wdata, arr_rdata, raw;
  assign req_ready = state == S_IDLE;
  assign rsp_valid = state == S_RESP;
  assign accept = req_valid && req_ready;
  assign off_full = req_addr - BASE_ADDR;
  assign misalign = (req_size == SZ_HALF && req_addr[0]) ||
                    (req_size == SZ_WORD && req_addr[1:0] != 2'b00) || req_size == SZ_RSVD;
`ifdef DMEM_BOUNDS_CHECK_EN
  // an address below BASE_ADDR wraps to a huge offset and fails the same compare
  assign range_err = off_full > ADDR_W'(DEPTH_BYTES) - ADDR_W'(size_bytes(req_size));
`else
  logic unused_off_hi;
  assign range_err = 1'b0;
  assign unused_off_hi = ^off_full[ADDR_W-1:AW];
`endif
  assign err = misalign || range_err;
  assign lane_we = accept && req_write && !err ?
                   (req_size == SZ_WORD ? 4'b1111 : req_size == SZ_HALF ? 4'b0011 : 4'b0001) : 4'b0000;
  assign lane_wdata = req_size == SZ_WORD ? req_wdata :
                      req_size == SZ_HALF ? {req_wdata[15:0], 16'h0000} : {req_wdata[7:0], 24'h000000};
  assign raw = req_size == SZ_WORD ? arr_rdata :
               req_size == SZ_HALF ? {16'h0000, arr_rdata[31:16]} : {24'h000000, arr_rdata[31:24]};
  dmem_byte_array #(.DEPTH_BYTES(DEPTH_BYTES)) u_array (
    .clock (clock),
    .offset(off_full[AW-1:0]),
    .we    (lane_we),
    .wdata (lane_wdata),
    .rdata (arr_rdata)
  );
  // next-state: optional wait phase, then hold the response until it is taken
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  state_n = req_valid ? (WAIT_STATES > 0 ? S_WAIT : S_RESP) : S_IDLE;
      S_WAIT:  state_n = wcnt == 4'(WAIT_STATES) ? S_RESP : S_WAIT;
      S_RESP:  state_n = rsp_ready ? S_IDLE : S_RESP;
      default: state_n = S_IDLE;
    endcase
  end
  // state register and wait counter counting 1..WAIT_STATES while in WAIT
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= S_IDLE;
      wcnt  <= 4'd0;
    end else begin
      state <= state_n;
      wcnt  <= state_n != S_WAIT ? 4'd0 : state == S_WAIT ? wcnt + 4'd1 : 4'd1;
    end
  // capture the response at the accept edge; stores and errors return zero data
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else if (accept) begin
      rsp_error <= err;
      rsp_rdata <= err || req_write ? 32'h0 : extend(raw, req_size, req_unsigned);
    end
endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb_data_memory_ctrl: scoreboard bench with a byte-level reference model of the data memory
module tb_data_memory_ctrl;
  localparam int          WS    = 3;
  localparam logic [31:0] BASE  = 32'h8002_0000;
  localparam int          DEPTH = 4096;
  typedef struct {logic err; logic [31:0] data; string name;} exp_t;
  logic clock = 1'b0, reset_n = 1'b0;
  logic req_valid = 1'b0, req_ready, req_write = 1'b0, req_unsigned = 1'b0;
  logic [1:0] req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic rsp_valid, rsp_ready = 1'b0, rsp_error;
  logic [31:0] rsp_rdata;
  exp_t exp_q[$];
  logic [7:0] mm [DEPTH];
  int checks = 0, errors = 0;
  bit hold_off = 0;
  bit lat_pend = 0, stall = 0;
  int lat_cyc = 0;
  logic [31:0] prev_d;
  logic prev_e;

  data_memory_ctrl #(.ADDR_W(32), .BASE_ADDR(BASE), .DEPTH_BYTES(DEPTH), .WAIT_STATES(WS)) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  function automatic exp_t model(input bit wr, input int sz, input bit uns, input logic [31:0] addr,
                                 input logic [31:0] wd, input string name);
    exp_t e;
    int nb;
    longint off;
    logic [63:0] v;
    nb = sz == 0 ? 1 : sz == 1 ? 2 : sz == 2 ? 4 : 0;
    e.name = name;
    e.err = 0;
    e.data = 0;
    off = longint'(addr) - longint'(BASE);
`ifdef DMEM_BOUNDS_CHECK_EN
    if (off < 0 || off > DEPTH - nb) e.err = 1;
`else
    off = off & (DEPTH - 1);
`endif
    if (nb == 0 || addr % nb != 0) e.err = 1;
    if (e.err) return e;
    if (wr) begin
      for (int k = 0; k < nb; k++) mm[off + k] = 8'(wd >> (8 * (nb - 1 - k)));
    end else begin
      v = 0;
      for (int k = 0; k < nb; k++) v = (v << 8) | 64'(mm[off + k]);
      if (!uns && v[8 * nb - 1]) v = v - (64'd1 << (8 * nb));
      e.data = v[31:0];
    end
    return e;
  endfunction

  task automatic issue(input bit wr, input int sz, input bit uns, input logic [31:0] addr,
                       input logic [31:0] wd, input string name);
    int n = 0;
    while (!req_ready && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    if (!req_ready) begin
      chk({name, " req_ready timeout"}, 32'(req_ready), 1);
      return;
    end
    req_valid = 1; req_write = wr; req_size = 2'(sz); req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    exp_q.push_back(model(wr, sz, uns, addr, wd, name));
    @(posedge clock); #1;
    req_valid = 0; req_write = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clock); #1;
      n++;
    end
    chk({name, " drain"}, 32'(exp_q.size()), 0);
  endtask

  always @(posedge clock) begin
    #1;
    rsp_ready = hold_off ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  always @(negedge clock) begin
    exp_t e;
    if (!reset_n) begin
      lat_pend = 0;
      stall = 0;
    end else begin
      if (lat_pend) begin
        lat_cyc++;
        if (rsp_valid) begin
          chk("latency cycle", 32'(lat_cyc), 32'(WS + 1));
          lat_pend = 0;
        end else begin
          chk("req_ready in wait", 32'(req_ready), 0);
          if (lat_cyc > 40) begin
            chk("rsp_valid timeout", 32'(rsp_valid), 1);
            lat_pend = 0;
          end
        end
      end
      if (stall) begin
        chk("stall rsp_valid", 32'(rsp_valid), 1);
        chk("stall rsp_rdata", rsp_rdata, prev_d);
        chk("stall rsp_error", 32'(rsp_error), 32'(prev_e));
      end
      if (rsp_valid) begin
        chk("req_ready in resp", 32'(req_ready), 0);
        if (rsp_ready) begin
          chk("response expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({e.name, " rsp_error"}, 32'(rsp_error), 32'(e.err));
            chk({e.name, " rsp_rdata"}, rsp_rdata, e.data);
          end
        end
        stall = !rsp_ready;
        prev_d = rsp_rdata;
        prev_e = rsp_error;
      end else stall = 0;
      if (req_valid && req_ready) begin
        lat_pend = 1;
        lat_cyc = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #12;
    chk("reset req_ready", 32'(req_ready), 1);
    chk("reset rsp_valid", 32'(rsp_valid), 0);
    chk("reset rsp_rdata", rsp_rdata, 0);
    chk("reset rsp_error", 32'(rsp_error), 0);
    @(posedge clock); #1;
    reset_n = 1;
    for (int i = 0; i < 16; i++) issue(1, 2, 0, BASE + 32'(4 * i), $urandom, "init sw");
    issue(1, 2, 0, BASE + 32'h10, 32'h1122_3344, "sw 0x10");
    issue(0, 2, 0, BASE + 32'h10, 0, "lw 0x10");
    issue(0, 0, 1, BASE + 32'h13, 0, "lbu 0x13");
    issue(1, 0, 0, BASE + 32'h20, 32'h0000_0080, "sb 0x20");
    issue(0, 0, 0, BASE + 32'h20, 0, "lb 0x20");
    issue(0, 0, 1, BASE + 32'h20, 0, "lbu 0x20");
    issue(1, 1, 0, BASE + 32'h22, 32'h0000_BEEF, "sh 0x22");
    issue(0, 1, 0, BASE + 32'h22, 0, "lh 0x22");
    issue(0, 1, 1, BASE + 32'h22, 0, "lhu 0x22");
    issue(0, 2, 0, BASE + 32'h02, 0, "lw misaligned 0x02");
    issue(1, 1, 0, BASE + 32'h01, 32'h0000_A5A5, "sh misaligned 0x01");
    issue(0, 2, 0, BASE + 32'h00, 0, "lw 0x00 after bad sh");
    issue(0, 3, 0, BASE + 32'h04, 0, "reserved size");
    drain("directed");
    hold_off = 1;
    issue(0, 2, 0, BASE + 32'h10, 0, "lw stalled");
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    chk("stall rsp_valid seen", 32'(rsp_valid), 1);
    repeat (5) @(posedge clock);
    #1;
    hold_off = 0;
    drain("stall");
    issue(1, 2, 0, BASE + 32'h30, 32'hCAFE_F00D, "sw before reset");
    #2;
    reset_n = 0;
    #1;
    chk("mid reset rsp_valid", 32'(rsp_valid), 0);
    chk("mid reset req_ready", 32'(req_ready), 1);
    exp_q.delete();
    @(posedge clock); #1;
    reset_n = 1;
    chk("post reset rsp_valid", 32'(rsp_valid), 0);
    chk("post reset req_ready", 32'(req_ready), 1);
    chk("post reset rsp_rdata", rsp_rdata, 0);
    issue(0, 2, 0, BASE + 32'h30, 0, "lw after reset");
    issue(0, 2, 0, BASE + 32'h1000, 0, "lw 0x1000 range/alias");
    drain("reset");
    for (int i = 0; i < 150; i++)
      issue(1'($urandom), $urandom_range(0, 3), 1'($urandom),
            BASE + ($urandom_range(0, 7) == 0 ? 32'h1000 : 32'h0) + 32'($urandom_range(0, 63)),
            $urandom, "random");
    drain("random");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
